mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the IF stage (instruction reads) and the MEM stage (data reads/writes) of the 5-stage MIPS pipeline.
- Sequences each access with a wait-state counter.
- Returns read data through registered outputs.
- Generates the freeze signals that stall the IF stage and the whole pipeline while an access is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter_wait_state_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, counter width
// and the latched request type.
package mem_arb_pkg;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_ACC   = 3'd1,
        MEM_ACC  = 3'd2,
        DONE_IF  = 3'd3,
        DONE_MEM = 3'd4
    } state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_type_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, freeze and memory-side signals of the arbiter, bundled.
// The slave modport is the arbiter; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze_if;
    logic              freeze_pipe;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
               ram_addr, ram_wdata, ram_we, ram_oe
    );

    modport master (
        output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
               ram_addr, ram_wdata, ram_we, ram_oe
    );
endinterface

// File: rtl/mem_port_arbiter_wait_state_counter.sv
// Wait-state counter: restarts at 0 on start, then counts up and parks at
// WAIT_CYCLES-1 with last held high until the next start.
module wait_state_counter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             last,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          count_q <= '0;
        else if (start)    count_q <= '0;
        else if (!last)    count_q <= count_q + CNT_W'(1);
    end

    assign count = count_q;
    assign last  = (count_q == LAST_V);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between IF fetches and MEM
// loads/stores; MEM wins ties, and freezes stall the pipeline meanwhile.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    state_e            state_q, state_d;
    req_type_e         typ_q, typ_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q, if_rdata_q, mem_rdata_q;
    logic              ram_we_q, ram_oe_q;
    logic              start, mem_gnt, last, acc_last, mem_ready;
    logic [CNT_W-1:0]  count;
    logic              unused_cnt;

    wait_state_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .last  (last),
        .count (count)
    );
    assign unused_cnt = ^count;

    always_comb begin
        state_d = state_q;
        typ_d   = typ_q;
        start   = 1'b0;
        mem_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                // MEM holds the older instruction, so it is served first
                if (bus.mem_rd_req || bus.mem_wr_req) begin
                    state_d = MEM_ACC;
                    typ_d   = bus.mem_wr_req ? WR : RD;
                    start   = 1'b1;
                    mem_gnt = 1'b1;
                end else if (bus.if_req) begin
                    state_d = IF_ACC;
                    typ_d   = RD;
                    start   = 1'b1;
                end
            end
            IF_ACC:  if (last) state_d = DONE_IF;
            MEM_ACC: if (last) state_d = DONE_MEM;
            default: state_d = IDLE;
        endcase
    end

    assign acc_last = ((state_q == IF_ACC) || (state_q == MEM_ACC)) && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            typ_q       <= RD;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            typ_q   <= typ_d;
            // Memory-side controls are frozen at grant; requester wiggles are ignored
            if (start) begin
                ram_addr_q  <= mem_gnt ? bus.mem_addr : bus.if_addr;
                ram_wdata_q <= mem_gnt ? bus.mem_wdata : '0;
                ram_we_q    <= (typ_d == WR);
                ram_oe_q    <= (typ_d == RD);
            end else if (acc_last) begin
                ram_we_q <= 1'b0;
                ram_oe_q <= 1'b0;
            end
            if (state_q == IF_ACC && last)
                if_rdata_q <= bus.ram_rdata;
            if (state_q == MEM_ACC && last && typ_q == RD)
                mem_rdata_q <= bus.ram_rdata;
        end
    end

    assign mem_ready       = (state_q == DONE_MEM);
    assign bus.mem_ready   = mem_ready;
    assign bus.if_ready    = (state_q == DONE_IF);
    assign bus.if_rdata    = if_rdata_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_oe      = ram_oe_q;
    assign bus.freeze_pipe = (bus.mem_rd_req | bus.mem_wr_req) & ~mem_ready;
    assign bus.freeze_if   = bus.freeze_pipe | (bus.if_req & ~(state_q == DONE_IF));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: WAIT_CYCLES=4 instance for most cases,
// WAIT_CYCLES=1 instance for back-to-back fetches. Read data is scoreboarded.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ba ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bb ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ba.slave));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bb.slave));

    int n_pass = 0;
    int n_tot  = 0;
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] last_mem_rd = '0;

    task automatic drive_idle();
        ba.if_req = 0; ba.if_addr = '0; ba.mem_rd_req = 0; ba.mem_wr_req = 0;
        ba.mem_addr = '0; ba.mem_wdata = '0; ba.ram_rdata = '0;
        bb.if_req = 0; bb.if_addr = '0; bb.mem_rd_req = 0; bb.mem_wr_req = 0;
        bb.mem_addr = '0; bb.mem_wdata = '0; bb.ram_rdata = '0;
    endtask

    task automatic test_reset();
        #2;
        n_tot++;
        if ({ba.if_rdata, ba.mem_rdata, ba.if_ready, ba.mem_ready, ba.ram_we, ba.ram_oe,
             ba.ram_addr, ba.ram_wdata, ba.freeze_if, ba.freeze_pipe} !== '0)
            $display("FAIL reset_a: outputs not all zero (rdata=%h we=%b oe=%b addr=%h)",
                     ba.if_rdata, ba.ram_we, ba.ram_oe, ba.ram_addr);
        else n_pass++;
        n_tot++;
        if ({bb.if_rdata, bb.if_ready, bb.ram_oe, bb.ram_addr} !== '0)
            $display("FAIL reset_b: got rdata=%h ready=%b oe=%b addr=%h, want 0",
                     bb.if_rdata, bb.if_ready, bb.ram_oe, bb.ram_addr);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    // IF read on dut_a starting at the current (IDLE) negedge; ends in IDLE cycle 6.
    task automatic run_if(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ba.if_req = 1; ba.if_addr = addr; ba.ram_rdata = data;
        if_q.push_back(data);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_tot++;
            if (ba.freeze_if !== (c <= 4)) $display("FAIL if_freeze c%0d: got %b want %b", c, ba.freeze_if, (c <= 4));
            else n_pass++;
            n_tot++;
            if (ba.ram_oe !== (c >= 1 && c <= 4) || ba.ram_we !== 1'b0)
                $display("FAIL if_oe c%0d: got oe=%b we=%b want oe=%b we=0", c, ba.ram_oe, ba.ram_we, (c >= 1 && c <= 4));
            else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_tot++;
                if (ba.ram_addr !== addr) $display("FAIL if_addr c%0d: got %h want %h", c, ba.ram_addr, addr);
                else n_pass++;
            end
            n_tot++;
            if (ba.if_ready !== (c == 5)) $display("FAIL if_ready c%0d: got %b want %b", c, ba.if_ready, (c == 5));
            else n_pass++;
            if (ba.if_ready === 1'b1 && if_q.size() > 0) begin
                exp_d = if_q.pop_front();
                n_tot++;
                if (ba.if_rdata !== exp_d) $display("FAIL if_rdata: got %h want %h", ba.if_rdata, exp_d);
                else n_pass++;
            end
            if (c == 5) ba.if_req = 0;
        end
        n_tot++;
        if (if_q.size() != 0) begin
            $display("FAIL if_done: %0d fetch(es) never returned, want 0", if_q.size());
            if_q.delete();
        end else n_pass++;
    endtask

    task automatic test_if_read();
        run_if(32'h10, 32'hDEADBEEF);
    endtask

    task automatic test_mem_read();
        ba.mem_rd_req = 1; ba.mem_addr = 32'h200; ba.ram_rdata = 32'hCAFEF00D;
        mem_q.push_back(32'hCAFEF00D);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_tot++;
            if (ba.freeze_pipe !== (c <= 4) || ba.ram_oe !== (c >= 1 && c <= 4))
                $display("FAIL mrd_ctl c%0d: got fp=%b oe=%b want fp=%b oe=%b", c, ba.freeze_pipe, ba.ram_oe, (c <= 4), (c >= 1 && c <= 4));
            else n_pass++;
            n_tot++;
            if (ba.mem_ready !== (c == 5)) $display("FAIL mrd_ready c%0d: got %b want %b", c, ba.mem_ready, (c == 5));
            else n_pass++;
            if (ba.mem_ready === 1'b1 && mem_q.size() > 0) begin
                exp_d = mem_q.pop_front();
                n_tot++;
                if (ba.mem_rdata !== exp_d) $display("FAIL mrd_rdata: got %h want %h", ba.mem_rdata, exp_d);
                else n_pass++;
                last_mem_rd = exp_d;
            end
            if (c == 5) ba.mem_rd_req = 0;
        end
        n_tot++;
        if (mem_q.size() != 0) begin
            $display("FAIL mrd_done: %0d load(s) never returned, want 0", mem_q.size());
            mem_q.delete();
        end else n_pass++;
    endtask

    // Store; rd_too also raises mem_rd_req to check write wins.
    task automatic run_write(input logic rd_too, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int we_cnt = 0;
        ba.mem_wr_req = 1; ba.mem_rd_req = rd_too; ba.mem_addr = addr; ba.mem_wdata = wd;
        ba.ram_rdata = 32'hBAD0BAD0;
        mem_q.push_back(last_mem_rd);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ba.ram_we === 1'b1) we_cnt++;
            n_tot++;
            if (ba.ram_we !== (c >= 1 && c <= 4) || ba.ram_oe !== 1'b0)
                $display("FAIL wr_ctl c%0d: got we=%b oe=%b want we=%b oe=0", c, ba.ram_we, ba.ram_oe, (c >= 1 && c <= 4));
            else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_tot++;
                if (ba.ram_addr !== addr || ba.ram_wdata !== wd)
                    $display("FAIL wr_bus c%0d: got %h/%h want %h/%h", c, ba.ram_addr, ba.ram_wdata, addr, wd);
                else n_pass++;
            end
            n_tot++;
            if (ba.freeze_pipe !== (c <= 4)) $display("FAIL wr_freeze c%0d: got %b want %b", c, ba.freeze_pipe, (c <= 4));
            else n_pass++;
            n_tot++;
            if (ba.mem_ready !== (c == 5)) $display("FAIL wr_ready c%0d: got %b want %b", c, ba.mem_ready, (c == 5));
            else n_pass++;
            if (ba.mem_ready === 1'b1 && mem_q.size() > 0) begin
                exp_d = mem_q.pop_front();
                n_tot++;
                if (ba.mem_rdata !== exp_d) $display("FAIL wr_rdata_kept: got %h want %h", ba.mem_rdata, exp_d);
                else n_pass++;
            end
            if (c == 2) begin ba.mem_addr = 32'h999; ba.mem_wdata = 32'h0; end
            if (c == 5) begin ba.mem_wr_req = 0; ba.mem_rd_req = 0; end
        end
        n_tot++;
        if (we_cnt != 4 || mem_q.size() != 0) begin
            $display("FAIL wr_count: got %0d we cycles, %0d pending, want 4, 0", we_cnt, mem_q.size());
            mem_q.delete();
        end else n_pass++;
    endtask

    task automatic test_mem_write();
        run_write(1'b0, 32'h400, 32'h12345678);
    endtask

    task automatic test_rd_wr_both();
        run_write(1'b1, 32'h500, 32'hA5A5A5A5);
    endtask

    task automatic test_priority();
        ba.if_req = 1; ba.if_addr = 32'h20; ba.mem_rd_req = 1; ba.mem_addr = 32'h300;
        ba.ram_rdata = 32'h11111111;
        mem_q.push_back(32'h11111111);
        if_q.push_back(32'h22222222);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_tot++;
            if (ba.mem_ready !== (c == 5) || ba.if_ready !== (c == 11))
                $display("FAIL pri_ready c%0d: got mem=%b if=%b want mem=%b if=%b", c, ba.mem_ready, ba.if_ready, (c == 5), (c == 11));
            else n_pass++;
            if ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) begin
                n_tot++;
                if (ba.ram_addr !== ((c <= 4) ? 32'h300 : 32'h20) || ba.ram_oe !== 1'b1)
                    $display("FAIL pri_addr c%0d: got %h oe=%b want %h oe=1", c, ba.ram_addr, ba.ram_oe, ((c <= 4) ? 32'h300 : 32'h20));
                else n_pass++;
            end
            if (c == 6) begin
                n_tot++;
                if (dut_a.state_q !== IDLE || ba.ram_oe !== 1'b0)
                    $display("FAIL pri_bubble: got state=%0d oe=%b want IDLE oe=0", dut_a.state_q, ba.ram_oe);
                else n_pass++;
            end
            if (ba.mem_ready === 1'b1 && mem_q.size() > 0) begin
                exp_d = mem_q.pop_front();
                n_tot++;
                if (ba.mem_rdata !== exp_d) $display("FAIL pri_mem_rdata: got %h want %h", ba.mem_rdata, exp_d);
                else n_pass++;
                last_mem_rd = exp_d;
            end
            if (ba.if_ready === 1'b1 && if_q.size() > 0) begin
                exp_d = if_q.pop_front();
                n_tot++;
                if (ba.if_rdata !== exp_d) $display("FAIL pri_if_rdata: got %h want %h", ba.if_rdata, exp_d);
                else n_pass++;
            end
            if (c == 5) begin ba.mem_rd_req = 0; ba.ram_rdata = 32'h22222222; end
            if (c == 11) ba.if_req = 0;
        end
        n_tot++;
        if (if_q.size() != 0 || mem_q.size() != 0) begin
            $display("FAIL pri_done: pending if=%0d mem=%0d, want 0", if_q.size(), mem_q.size());
            if_q.delete(); mem_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        ba.mem_wr_req = 1; ba.mem_addr = 32'h600; ba.mem_wdata = 32'h55;
        @(negedge clk); @(negedge clk);
        #1;
        n_tot++;
        if (ba.ram_we !== 1'b1) $display("FAIL rst_pre_we: got %b want 1", ba.ram_we);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_tot++;
        if (ba.ram_we !== 1'b0) $display("FAIL rst_async_we: got %b want 0", ba.ram_we);
        else n_pass++;
        n_tot++;
        if ({ba.if_rdata, ba.mem_rdata, ba.if_ready, ba.mem_ready, ba.ram_oe, ba.ram_addr, ba.ram_wdata} !== '0
            || dut_a.state_q !== IDLE)
            $display("FAIL rst_outputs: got mem_rdata=%h addr=%h state=%0d want 0/0/IDLE",
                     ba.mem_rdata, ba.ram_addr, dut_a.state_q);
        else n_pass++;
        ba.mem_wr_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_tot++;
            if (ba.mem_ready !== 1'b0 || ba.ram_we !== 1'b0 || ba.freeze_pipe !== 1'b0)
                $display("FAIL rst_hold c%0d: got ready=%b we=%b fp=%b want 0", c, ba.mem_ready, ba.ram_we, ba.freeze_pipe);
            else n_pass++;
        end
        rst = 1'b1;
        run_if(32'h44, 32'h00000077);
    endtask

    task automatic test_back_to_back();
        bb.if_req = 1; bb.if_addr = 32'h80; bb.ram_rdata = 32'h0B0B0001;
        if_q.push_back(32'h0B0B0001);
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_tot++;
            if (bb.if_ready !== (c == 2 || c == 5) || bb.ram_oe !== (c == 1 || c == 4))
                $display("FAIL b2b c%0d: got ready=%b oe=%b want ready=%b oe=%b", c, bb.if_ready, bb.ram_oe, (c == 2 || c == 5), (c == 1 || c == 4));
            else n_pass++;
            if (c == 4) begin
                n_tot++;
                if (bb.ram_addr !== 32'h84) $display("FAIL b2b_addr: got %h want %h", bb.ram_addr, 32'h84);
                else n_pass++;
            end
            if (bb.if_ready === 1'b1 && if_q.size() > 0) begin
                exp_d = if_q.pop_front();
                n_tot++;
                if (bb.if_rdata !== exp_d) $display("FAIL b2b_rdata c%0d: got %h want %h", c, bb.if_rdata, exp_d);
                else n_pass++;
            end
            if (c == 2) begin
                bb.if_addr = 32'h84; bb.ram_rdata = 32'h0B0B0002;
                if_q.push_back(32'h0B0B0002);
            end
            if (c == 5) bb.if_req = 0;
        end
        n_tot++;
        if (if_q.size() != 0) begin
            $display("FAIL b2b_done: %0d fetch(es) never returned, want 0", if_q.size());
            if_q.delete();
        end else n_pass++;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_if_read();
        test_mem_read();
        test_mem_write();
        test_priority();
        test_rd_wr_both();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
